// File: rtl/fanout_pkg.sv
// Shared types and limits for the fanout fork tracker and its branch slots.
package fanout_pkg;

  typedef enum logic {
    FANOUT_LAZY  = 1'b0,
    FANOUT_EAGER = 1'b1
  } fanout_mode_e;

  localparam int FANOUT_MAX_OUT = 32;

endpackage

// File: rtl/fanout_branch_slot.sv
// One downstream branch: holds its taken flop and derives active, satisfied and valid.
module fanout_branch_slot
  import fanout_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  fanout_mode_e mode,
  input  logic         ignore,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         in_ready,
  input  logic         accept,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         sat,
  output logic         taken
);

  logic taken_reg;
  logic active;
  logic eager;
  logic fire;

  assign eager  = (mode == FANOUT_EAGER);
  assign active = en & ~ignore;
  assign sat    = ~active | taken_reg | out_ready;

  // Lazy branches wait for the whole group; eager ones only for their own taken bit.
  assign out_valid = in_valid & active & (eager ? ~taken_reg : in_ready);
  assign fire      = out_valid & out_ready;
  assign taken     = taken_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_reg <= 1'b0;
    end else if (flush) begin
      taken_reg <= 1'b0;
    end else if (accept) begin
      taken_reg <= 1'b0;
    end else if (eager && in_valid) begin
      taken_reg <= taken_reg | fire;
    end
  end

endmodule

// File: rtl/fanout_fork_tracker.sv
// Broadcasts one upstream token to NUM_OUT branches; releases upstream once all active branches are satisfied.
module fanout_fork_tracker
  import fanout_pkg::*;
#(
  parameter int NUM_OUT = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_OUT-1:0] cfg_en,
  input  logic               cfg_mode,
  input  logic [NUM_OUT-1:0] ignore,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] taken,
  output logic [CNT_W-1:0]   tok_count
);

  fanout_mode_e       mode;
  logic [NUM_OUT-1:0] sat;
  logic               accept;
  logic [CNT_W-1:0]   tok_count_reg;

  assign mode     = fanout_mode_e'(cfg_mode);
  assign in_ready = &sat;
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_slot
      fanout_branch_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .en        (cfg_en[gi]),
        .mode      (mode),
        .ignore    (ignore[gi]),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .accept    (accept),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .sat       (sat[gi]),
        .taken     (taken[gi])
      );
    end
  endgenerate

  // Counter survives flush; it only tracks completed upstream handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_count_reg <= '0;
    end else if (accept && (tok_count_reg != {CNT_W{1'b1}})) begin
      tok_count_reg <= tok_count_reg + 1'b1;
    end
  end

  assign tok_count = tok_count_reg;

endmodule

// File: tb/tb_fanout_fork_tracker.sv
// Directed checks of the fanout fork tracker: combinational vector table plus multi-cycle sequences.
module tb_fanout_fork_tracker;

  localparam int N = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  cfg_en = '0;
  logic          cfg_mode = 1'b0;
  logic [N-1:0]  ignore = '0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '0;
  logic [N-1:0]  taken;
  logic [CW-1:0] tok_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fanout_fork_tracker #(.NUM_OUT(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .cfg_mode  (cfg_mode),
    .ignore    (ignore),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .tok_count (tok_count)
  );

  typedef struct {
    logic         mode;
    logic [N-1:0] en;
    logic [N-1:0] ign;
    logic         iv;
    logic [N-1:0] rdy;
    logic [N-1:0] exp_ov;
    logic         exp_ir;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven and registers sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            mode  en      ign     iv    rdy     exp_ov  exp_ir
    vecs[0] = '{1'b0, 9'h1FF, 9'h000, 1'b1, 9'h1FF, 9'h1FF, 1'b1};
    vecs[1] = '{1'b0, 9'h1FF, 9'h000, 1'b1, 9'h1FE, 9'h000, 1'b0};
    vecs[2] = '{1'b0, 9'h1FF, 9'h001, 1'b1, 9'h1FE, 9'h1FE, 1'b1};
    vecs[3] = '{1'b0, 9'h000, 9'h000, 1'b1, 9'h000, 9'h000, 1'b1};
    vecs[4] = '{1'b1, 9'h007, 9'h000, 1'b1, 9'h001, 9'h007, 1'b0};
    vecs[5] = '{1'b1, 9'h007, 9'h000, 1'b1, 9'h007, 9'h007, 1'b1};
    vecs[6] = '{1'b1, 9'h1FF, 9'h000, 1'b0, 9'h000, 9'h000, 1'b0};
    vecs[7] = '{1'b0, 9'h1FF, 9'h000, 1'b0, 9'h1FF, 9'h000, 1'b1};
    vecs[8] = '{1'b1, 9'h0F0, 9'h030, 1'b1, 9'h0C0, 9'h0C0, 1'b1};

    #12;
    check("reset_taken", 32'(taken), 32'h0);
    check("reset_tok", 32'(tok_count), 32'h0);
    check("reset_ov", 32'(out_valid), 32'h0);
    tick();
    reset = 1'b0;

    // Each vector is applied with taken cleared and withdrawn before the edge.
    for (int v = 0; v < 9; v++) begin
      tick();
      flush = 1'b0;
      cfg_mode = vecs[v].mode;
      cfg_en = vecs[v].en;
      ignore = vecs[v].ign;
      in_valid = vecs[v].iv;
      out_ready = vecs[v].rdy;
      #1;
      check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
      check($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ir));
      #1;
      in_valid = 1'b0;
      flush = 1'b1;
    end
    tick();
    flush = 1'b0;
    ignore = '0;
    check("table_no_accepts", 32'(tok_count), 32'h0);

    // Lazy single pulse, all ready
    cfg_mode = 1'b0; cfg_en = 9'h1FF; out_ready = 9'h1FF; in_valid = 1'b1;
    #1;
    check("lazy_ov", 32'(out_valid), 32'h1FF);
    check("lazy_ir", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("lazy_tok", 32'(tok_count), 32'h1);
    check("lazy_taken", 32'(taken), 32'h0);

    // Eager, branches take one per cycle
    cfg_mode = 1'b1; cfg_en = 9'h007; in_valid = 1'b1; out_ready = 9'h001;
    #1;
    check("eager_c0_ov", 32'(out_valid), 32'h007);
    check("eager_c0_ir", 32'(in_ready), 32'h0);
    tick();
    check("eager_c0_taken", 32'(taken), 32'h001);
    out_ready = 9'h002;
    #1;
    check("eager_c1_ov", 32'(out_valid), 32'h006);
    check("eager_c1_ir", 32'(in_ready), 32'h0);
    tick();
    check("eager_c1_taken", 32'(taken), 32'h003);
    out_ready = 9'h004;
    #1;
    check("eager_c2_ov", 32'(out_valid), 32'h004);
    check("eager_c2_ir", 32'(in_ready), 32'h1);
    tick();
    check("eager_c2_taken", 32'(taken), 32'h000);
    check("eager_tok", 32'(tok_count), 32'h2);

    // Ignore releases a stalled branch
    cfg_en = 9'h003; out_ready = 9'h001;
    tick();
    check("ign_taken", 32'(taken), 32'h001);
    out_ready = 9'h000;
    #1;
    check("ign_stall_ir", 32'(in_ready), 32'h0);
    check("ign_stall_ov", 32'(out_valid), 32'h002);
    ignore = 9'h002;
    #1;
    check("ign_raise_ir", 32'(in_ready), 32'h1);
    tick();
    check("ign_done_taken", 32'(taken), 32'h000);
    check("ign_tok", 32'(tok_count), 32'h3);
    ignore = '0;

    // Flush drops pending taken state
    cfg_en = 9'h007; out_ready = 9'h005;
    tick();
    check("flush_pre_taken", 32'(taken), 32'h005);
    out_ready = 9'h000; flush = 1'b1;
    #1;
    check("flush_pending_ov", 32'(out_valid), 32'h002);
    tick();
    flush = 1'b0;
    check("flush_taken", 32'(taken), 32'h000);
    #1;
    check("flush_ov", 32'(out_valid), 32'h007);
    check("flush_tok", 32'(tok_count), 32'h3);

    // Asynchronous reset mid-token
    out_ready = 9'h001;
    tick();
    out_ready = 9'h002;
    tick();
    check("areset_pre_taken", 32'(taken), 32'h003);
    out_ready = 9'h000;
    #1;
    reset = 1'b1;
    #1;
    check("areset_taken", 32'(taken), 32'h0);
    check("areset_tok", 32'(tok_count), 32'h0);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;

    // No active branches: tokens drop every cycle and the counter saturates
    tick();
    cfg_en = '0; in_valid = 1'b1;
    #1;
    check("drop_ir", 32'(in_ready), 32'h1);
    check("drop_ov", 32'(out_valid), 32'h0);
    tick();
    check("drop_tok1", 32'(tok_count), 32'h1);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_tok", 32'(tok_count), 32'hFFFF);
    tick();
    check("sat_hold", 32'(tok_count), 32'hFFFF);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fanout_fork_tracker.md
Name: fanout_fork_tracker

Overview:
- Parametrised successor to the fixed 9-way fanout ready-combiner in the sparse-stream (SAM/Onyx) interconnect.
- Broadcasts one upstream valid/ready token to NUM_OUT downstream branches, each with a runtime enable and a dynamic ignore.
- Adds an EAGER mode: a per-branch "taken" register lets each branch accept independently, and the upstream is released only once every active branch has taken the token.
- LAZY mode reproduces the legacy all-ready-at-once behaviour.

Parameters:
NUM_OUT, 9, number of downstream branches (1..32)
CNT_W, 16, width of the saturating token counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
cfg_en  input  NUM_OUT  per-branch enable (config, quasi-static)
cfg_mode  input  1  0 = LAZY, 1 = EAGER
ignore  input  NUM_OUT  dynamic per-branch ignore; an ignored branch counts as satisfied
flush  input  1  synchronous clear of taken state
in_valid  input  1  upstream token valid
in_ready  output  1  upstream token accepted when high with in_valid
out_valid  output  NUM_OUT  per-branch valid
out_ready  input  NUM_OUT  per-branch ready
taken  output  NUM_OUT  registered per-branch taken vector (status)
tok_count  output  CNT_W  saturating count of upstream handshakes

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset. All state clears immediately on reset assertion.
- Reset values:
  - taken = 0, tok_count = 0.
  - in_valid = 0 drives out_valid = 0.
  - in_ready follows the combinational equations below.
- Per-branch terms:
  - active[i] = cfg_en[i] & ~ignore[i]
  - sat[i] = ~active[i] | taken[i] | out_ready[i]
- in_ready = AND over i of sat[i].
  - No active branches: in_ready = 1 and the token is consumed (dropped).
  - LAZY mode: taken is always 0, so in_ready = AND(~active | out_ready). This equals the legacy combiner.
- out_valid[i]:
  - EAGER: in_valid & active[i] & ~taken[i]. No dependence on other branches' ready.
  - LAZY: in_valid & active[i] & in_ready. This is a combinational ready-to-valid path across branches; it is documented and allowed.
- fire[i] = out_valid[i] & out_ready[i]. accept = in_valid & in_ready.
- taken next-state, in priority order:
  1. reset: 0
  2. flush: 0
  3. accept: 0 (the token completes this cycle)
  4. EAGER and in_valid: taken | fire
  5. otherwise: unchanged
- Latency:
  - Zero-cycle combinational path from in_valid/out_ready to out_valid/in_ready.
  - A branch that fires early is masked from the next cycle on; there is no duplicate delivery.
- Simultaneous events:
  - The last pending branch firing in the same cycle as others completes the token in that cycle.
  - flush together with accept: accept still completes upstream; taken = 0.
- Ignore raised on a pending branch: that branch becomes satisfied immediately. A taken bit already set is kept until the token completes.
- Mode change or cfg_en change is legal only while in_valid = 0 or after flush. Otherwise the behaviour is defined by the equations above, with no extra protection.
- in_valid dropping mid-token (a protocol violation): taken is held, and the next token skips the already-taken branches. The bench must not rely on this; flush recovers.
- tok_count: increments on accept and saturates at 2^CNT_W-1. It is not cleared by flush.

Decomposition:
- Shared package fanout_pkg:
  - enum fanout_mode_e {FANOUT_LAZY = 1'b0, FANOUT_EAGER = 1'b1}
  - constant FANOUT_MAX_OUT = 32
- One sub-module, fanout_branch_slot, instantiated NUM_OUT times. It holds the taken flop and computes active/sat/out_valid/fire for one branch.
- The top level holds the AND-reduction, accept logic and tok_count.

Test Plan:
- LAZY, NUM_OUT = 9, cfg_en = 0x1FF, ignore = 0, all ready. In_valid pulse → out_valid = 0x1FF, in_ready = 1, tok_count = 1, taken stays 0.
- EAGER, cfg_en = 0x007, in_valid held, out_ready = 0x001 (cycle 0), 0x002 (cycle 1), 0x004 (cycle 2):
  - out_valid = 0x007, then 0x006, then 0x004.
  - in_ready = 1 only in cycle 2; taken = 0x001, 0x003, then 0.
- EAGER, branch 1 stalled with taken = 0x001; raise ignore[1] → in_ready = 1 in the same cycle, taken = 0 next cycle.
- cfg_en = 0, in_valid = 1 → in_ready = 1, out_valid = 0, tok_count increments every cycle and saturates at 0xFFFF after 65535 accepts.
- EAGER, taken = 0x005 pending; assert flush → taken = 0 next cycle, out_valid returns to 0x007.
- Assert reset asynchronously mid-token with taken = 0x003 → taken = 0 and tok_count = 0 immediately, before the next clk edge.
